dmem_access_ctrl: RTL and testbench

//  Memory-stage data-memory access sequencer for the CPU pipeline. Takes one load/store per

---
 rtl/dmem_access_ctrl_pkg.sv | 34 +++
 rtl/dmem_access_ctrl_ld_extract.sv | 32 +++
 rtl/dmem_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access sequencer: one-hot access-type
// bit positions, bus size codes, queue entry layout and decode helpers.
package dmem_access_ctrl_pkg;

  localparam int T_LB  = 0;
  localparam int T_LBU = 1;
  localparam int T_LH  = 2;
  localparam int T_LHU = 3;
  localparam int T_LW  = 4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic       wr;
    logic [4:0] typ;
    logic [1:0] off;
    logic       cancel;
  } q_entry_t;

  function automatic logic [1:0] size_of(input logic [4:0] typ);
    if (typ[T_LW])                 return SIZE_WORD;
    else if (typ[T_LH] | typ[T_LHU]) return SIZE_HALF;
    else                           return SIZE_BYTE;
  endfunction

  function automatic logic misaligned(input logic [4:0] typ, input logic [1:0] off);
    logic [1:0] sz;
    sz = size_of(typ);
    return ((sz == SIZE_HALF) && off[0]) || ((sz == SIZE_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_ld_extract.sv
// Load-data extraction: picks the addressed byte/half lane out of the raw read
// word and sign- or zero-extends it according to the one-hot load type.
module dmem_access_ctrl_ld_extract
  import dmem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [4:0]  typ,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[7:0];
    case (off)
      2'd0:    byte_val = rdata[7:0];
      2'd1:    byte_val = rdata[15:8];
      2'd2:    byte_val = rdata[23:16];
      default: byte_val = rdata[31:24];
    endcase
    half_val = off[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    if (typ[T_LB])       data = {{24{byte_val[7]}}, byte_val};
    else if (typ[T_LBU]) data = {24'd0, byte_val};
    else if (typ[T_LH])  data = {{16{half_val[15]}}, half_val};
    else if (typ[T_LHU]) data = {16'd0, half_val};
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-memory access sequencer: one holding register feeding the
// SRAM-like bus, an in-order queue of outstanding accesses, and WB result return.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_valid,
  output logic        ms_ready,
  input  logic        ms_wr,
  input  logic [4:0]  ms_type,
  input  logic [31:0] ms_addr,
  input  logic [31:0] ms_wdata,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        wb_valid,
  output logic        wb_wr,
  output logic        wb_err,
  output logic [31:0] wb_rdata
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic        hold_valid, hold_err, hold_wr, hold_cancel;
  logic [4:0]  hold_type;
  logic [31:0] hold_addr, hold_wdata;

  q_entry_t           queue [MAX_OUTST];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  q_entry_t           head;
  logic [31:0]        ld_data;

  logic accept, acc_err, err_now, issue_req, push, pop, err_done;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ms_ready  = resetn & ~hold_valid & ~flush & (count < CNT_W'(MAX_OUTST));
  assign accept    = ms_valid & ms_ready;
  assign acc_err   = misaligned(ms_type, ms_addr[1:0]);
  // A misaligned access with nothing ahead of it completes straight from accept.
  assign err_now   = accept & acc_err & (count == '0);
  assign issue_req = hold_valid & ~hold_err;
  assign push      = issue_req & data_addr_ok;
  assign pop       = data_data_ok & (count != '0);
  assign err_done  = hold_valid & hold_err & (count == '0) & ~flush;
  assign head      = queue[rd_ptr];

  assign data_req  = issue_req;
  assign data_wr   = issue_req & hold_wr;
  assign data_size = issue_req ? size_of(hold_type) : 2'd0;
  assign data_addr = issue_req ? hold_addr : 32'd0;

  always_comb begin
    data_wstrb = 4'd0;
    data_wdata = 32'd0;
    if (issue_req) begin
      case (size_of(hold_type))
        SIZE_BYTE: begin
          data_wstrb = 4'b0001 << hold_addr[1:0];
          data_wdata = {4{hold_wdata[7:0]}};
        end
        SIZE_HALF: begin
          data_wstrb = hold_addr[1] ? 4'b1100 : 4'b0011;
          data_wdata = {2{hold_wdata[15:0]}};
        end
        default: begin
          data_wstrb = 4'b1111;
          data_wdata = hold_wdata;
        end
      endcase
      if (!hold_wr) data_wstrb = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid  <= 1'b0;
      hold_err    <= 1'b0;
      hold_wr     <= 1'b0;
      hold_cancel <= 1'b0;
      hold_type   <= 5'd0;
      hold_addr   <= 32'd0;
      hold_wdata  <= 32'd0;
    end else begin
      if (accept && !err_now) begin
        hold_valid  <= 1'b1;
        hold_err    <= acc_err;
        hold_wr     <= ms_wr;
        hold_cancel <= 1'b0;
        hold_type   <= ms_type;
        hold_addr   <= ms_addr;
        hold_wdata  <= ms_wdata;
      end else if (push || err_done || (flush && hold_valid && hold_err)) begin
        hold_valid  <= 1'b0;
        hold_err    <= 1'b0;
      end else if (flush) begin
        hold_cancel <= 1'b1;
      end
    end
  end

  // Flush marks every slot cancelled; a push in the same cycle overwrites its own
  // slot afterwards with the cancel bit folded in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < MAX_OUTST; i++) queue[i] <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < MAX_OUTST; i++) queue[i].cancel <= 1'b1;
      end
      if (push) begin
        queue[wr_ptr] <= '{wr: hold_wr, typ: hold_type, off: hold_addr[1:0],
                           cancel: hold_cancel | flush};
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  dmem_access_ctrl_ld_extract u_ld_extract (
    .rdata (data_rdata),
    .typ   (head.typ),
    .off   (head.off),
    .data  (ld_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_valid <= 1'b0;
      wb_wr    <= 1'b0;
      wb_err   <= 1'b0;
      wb_rdata <= 32'd0;
    end else begin
      wb_valid <= 1'b0;
      wb_wr    <= 1'b0;
      wb_err   <= 1'b0;
      wb_rdata <= 32'd0;
      if (pop) begin
        if (!head.cancel && !flush) begin
          wb_valid <= 1'b1;
          wb_wr    <= head.wr;
          wb_rdata <= head.wr ? 32'd0 : ld_data;
        end
      end else if (err_now) begin
        wb_valid <= 1'b1;
        wb_err   <= 1'b1;
        wb_wr    <= ms_wr;
      end else if (err_done) begin
        wb_valid <= 1'b1;
        wb_err   <= 1'b1;
        wb_wr    <= hold_wr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: table of single accesses plus
// hand-written sequences for stalls, misaligned ordering, flush and reset.
module tb_dmem_access_ctrl;

  localparam int MAX_OUTST = 2;

  localparam logic [4:0] TY_LB  = 5'b00001;
  localparam logic [4:0] TY_LBU = 5'b00010;
  localparam logic [4:0] TY_LH  = 5'b00100;
  localparam logic [4:0] TY_LHU = 5'b01000;
  localparam logic [4:0] TY_LW  = 5'b10000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_valid, ms_ready, ms_wr, flush;
  logic [4:0]  ms_type;
  logic [31:0] ms_addr, ms_wdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        wb_valid, wb_wr, wb_err;
  logic [31:0] wb_rdata;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ms_valid     (ms_valid),
    .ms_ready     (ms_ready),
    .ms_wr        (ms_wr),
    .ms_type      (ms_type),
    .ms_addr      (ms_addr),
    .ms_wdata     (ms_wdata),
    .flush        (flush),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .wb_valid     (wb_valid),
    .wb_wr        (wb_wr),
    .wb_err       (wb_err),
    .wb_rdata     (wb_rdata)
  );

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
  } wb_exp_t;

  typedef struct {
    logic        wr;
    logic [4:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] exp_wdata;
    logic        err;
    logic [31:0] exp_rdata;
  } vec_t;

  wb_exp_t exp_q[$];
  vec_t    vecs[13];
  int      n_vec  = 0;
  int      n_miss = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expectWb(input logic wr, input logic err, input logic [31:0] rdata);
    wb_exp_t e;
    e.wr = wr; e.err = err; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every WB pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wb_exp_t e;
    if (resetn === 1'b1 && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wb_wr", {31'd0, wb_wr}, {31'd0, e.wr});
        checkOutput("wb_err", {31'd0, wb_err}, {31'd0, e.err});
        checkOutput("wb_rdata", wb_rdata, e.rdata);
      end
    end
  end

  task automatic issue(input logic wr, input logic [4:0] typ, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n;
    @(negedge clk);
    ms_valid = 1'b1; ms_wr = wr; ms_type = typ; ms_addr = addr; ms_wdata = wdata;
    n = 0;
    while (!ms_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    ms_valid = 1'b0;
  endtask

  task automatic addrOk();
    checkOutput("addr_ok_req", {31'd0, data_req}, 32'd1);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
  endtask

  task automatic dataOk(input logic [31:0] r);
    data_data_ok = 1'b1;
    data_rdata   = r;
    @(negedge clk);
    data_data_ok = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    expectWb(v.wr, v.err, v.exp_rdata);
    issue(v.wr, v.typ, v.addr, v.wdata);
    if (v.err) begin
      checkOutput("err_no_req", {31'd0, data_req}, 32'd0);
      #1 checkOutput("err_latency", exp_q.size(), 32'd0);
    end else begin
      checkOutput("data_size", {30'd0, data_size}, {30'd0, v.size});
      checkOutput("data_addr", data_addr, v.addr);
      checkOutput("data_wr", {31'd0, data_wr}, {31'd0, v.wr});
      checkOutput("data_wstrb", {28'd0, data_wstrb}, {28'd0, v.wstrb});
      if (v.wr) checkOutput("data_wdata", data_wdata, v.exp_wdata);
      addrOk();
      dataOk(v.rdata);
      #1 checkOutput("wb_latency", exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, TY_LB,  32'h103, 32'h0,        32'h80FF_1234, 2'd0, 4'b0000, 32'h0,        1'b0, 32'hFFFF_FF80};
    vecs[1]  = '{1'b0, TY_LBU, 32'h103, 32'h0,        32'h80FF_1234, 2'd0, 4'b0000, 32'h0,        1'b0, 32'h0000_0080};
    vecs[2]  = '{1'b0, TY_LHU, 32'h102, 32'h0,        32'h8001_7F00, 2'd1, 4'b0000, 32'h0,        1'b0, 32'h0000_8001};
    vecs[3]  = '{1'b0, TY_LH,  32'h100, 32'h0,        32'h8001_7F00, 2'd1, 4'b0000, 32'h0,        1'b0, 32'h0000_7F00};
    vecs[4]  = '{1'b0, TY_LH,  32'h102, 32'h0,        32'h8001_7F00, 2'd1, 4'b0000, 32'h0,        1'b0, 32'hFFFF_8001};
    vecs[5]  = '{1'b0, TY_LW,  32'h104, 32'h0,        32'hDEAD_BEEF, 2'd2, 4'b0000, 32'h0,        1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, TY_LB,  32'h002, 32'h0000_00AB, 32'hFFFF_FFFF, 2'd0, 4'b0100, 32'hABAB_ABAB, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, TY_LH,  32'h002, 32'h0000_1234, 32'hFFFF_FFFF, 2'd1, 4'b1100, 32'h1234_1234, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, TY_LW,  32'h008, 32'hCAFE_F00D, 32'hFFFF_FFFF, 2'd2, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, TY_LB,  32'h001, 32'h9988_7755, 32'hFFFF_FFFF, 2'd0, 4'b0010, 32'h5555_5555, 1'b0, 32'h0};
    vecs[10] = '{1'b0, TY_LW,  32'h101, 32'h0,        32'h0,         2'd0, 4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[11] = '{1'b0, TY_LH,  32'h103, 32'h0,        32'h0,         2'd0, 4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[12] = '{1'b0, TY_LBU, 32'h101, 32'h0,        32'h0000_A500, 2'd0, 4'b0000, 32'h0,        1'b0, 32'h0000_00A5};

    resetn = 1'b0; ms_valid = 1'b1; ms_wr = 1'b0; ms_type = TY_LW; ms_addr = 32'h0;
    ms_wdata = 32'h0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ms_ready", {31'd0, ms_ready}, 32'd0);
    checkOutput("rst_data_req", {31'd0, data_req}, 32'd0);
    checkOutput("rst_data_wr", {31'd0, data_wr}, 32'd0);
    checkOutput("rst_data_size", {30'd0, data_size}, 32'd0);
    checkOutput("rst_data_addr", data_addr, 32'd0);
    checkOutput("rst_data_wstrb", {28'd0, data_wstrb}, 32'd0);
    checkOutput("rst_data_wdata", data_wdata, 32'd0);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_wr", {31'd0, wb_wr}, 32'd0);
    checkOutput("rst_wb_err", {31'd0, wb_err}, 32'd0);
    checkOutput("rst_wb_rdata", wb_rdata, 32'd0);
    ms_valid = 1'b0;
    resetn   = 1'b1;
    @(negedge clk);
    checkOutput("idle_ms_ready", {31'd0, ms_ready}, 32'd1);

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

    // Bus stall, fill to MAX_OUTST, then simultaneous push and pop.
    expectWb(1'b0, 1'b0, 32'h1111_2222);
    issue(1'b0, TY_LW, 32'h10, 32'h0);
    repeat (3) begin
      checkOutput("stall_req", {31'd0, data_req}, 32'd1);
      checkOutput("stall_addr", data_addr, 32'h10);
      checkOutput("stall_ready", {31'd0, ms_ready}, 32'd0);
      @(negedge clk);
    end
    addrOk();
    expectWb(1'b0, 1'b0, 32'h0000_BEEF);
    issue(1'b0, TY_LHU, 32'h22, 32'h0);
    addrOk();
    expectWb(1'b0, 1'b0, 32'hFFFF_FFC3);
    ms_valid = 1'b1; ms_wr = 1'b0; ms_type = TY_LB; ms_addr = 32'h31;
    repeat (2) begin
      checkOutput("full_ready", {31'd0, ms_ready}, 32'd0);
      @(negedge clk);
    end
    dataOk(32'h1111_2222);
    checkOutput("ready_after_pop", {31'd0, ms_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    ms_valid = 1'b0;
    checkOutput("req3_addr", data_addr, 32'h31);
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hBEEF_0001;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    checkOutput("push_pop_ready", {31'd0, ms_ready}, 32'd1);
    checkOutput("push_pop_req", {31'd0, data_req}, 32'd0);
    dataOk(32'h0000_C300);
    #1 checkOutput("seqA_drain", exp_q.size(), 32'd0);

    // Misaligned access waits behind an outstanding load.
    expectWb(1'b0, 1'b0, 32'h1234_5678);
    issue(1'b0, TY_LW, 32'h40, 32'h0);
    addrOk();
    expectWb(1'b0, 1'b1, 32'h0);
    issue(1'b0, TY_LW, 32'h41, 32'h0);
    checkOutput("mis_no_req", {31'd0, data_req}, 32'd0);
    checkOutput("mis_hold_ready", {31'd0, ms_ready}, 32'd0);
    repeat (2) @(negedge clk);
    dataOk(32'h1234_5678);
    @(negedge clk);
    #1 checkOutput("mis_after_load", exp_q.size(), 32'd0);

    // Flush with one outstanding and one presented: nothing reaches WB.
    issue(1'b0, TY_LW, 32'h50, 32'h0);
    addrOk();
    issue(1'b0, TY_LW, 32'h54, 32'h0);
    flush = 1'b1;
    checkOutput("flush_ready", {31'd0, ms_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_req_kept", {31'd0, data_req}, 32'd1);
    addrOk();
    checkOutput("flush_full_ready", {31'd0, ms_ready}, 32'd0);
    dataOk(32'hAAAA_AAAA);
    dataOk(32'hBBBB_BBBB);
    checkOutput("ready_after_drain", {31'd0, ms_ready}, 32'd1);
    repeat (2) @(negedge clk);

    // Flush drops a misaligned completion held behind a load.
    issue(1'b0, TY_LW, 32'h60, 32'h0);
    addrOk();
    issue(1'b0, TY_LH, 32'h61, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    dataOk(32'hCCCC_CCCC);
    repeat (3) @(negedge clk);
    checkOutput("flush_mis_ready", {31'd0, ms_ready}, 32'd1);

    applyStimulus(vecs[0]);

    // Asynchronous reset in the middle of an access.
    issue(1'b0, TY_LW, 32'h80, 32'h0);
    checkOutput("pre_rst_req", {31'd0, data_req}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async_rst_req", {31'd0, data_req}, 32'd0);
    checkOutput("async_rst_addr", data_addr, 32'd0);
    checkOutput("async_rst_ready", {31'd0, ms_ready}, 32'd0);
    checkOutput("async_rst_wb", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    dataOk(32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    checkOutput("post_rst_ready", {31'd0, ms_ready}, 32'd1);
    checkOutput("post_rst_req", {31'd0, data_req}, 32'd0);

    applyStimulus(vecs[2]);

    checkOutput("final_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
